// File: rtl/regfile_param.sv
// Parametrised 2-read / 1-write register file with optional zero register,
// optional write-to-read bypass and a per-register busy scoreboard that the
// issue logic uses to detect read-after-write hazards.
module regfile_param #(
    parameter int                DATA_W    = 16,
    parameter int                DEPTH     = 8,
    parameter int                ADDR_W    = 4,
    parameter int                ZERO_REG  = 0,
    parameter int                BYPASS    = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    localparam int               CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr,
    output logic              busy1,
    output logic              busy2,
    output logic [CNT_W-1:0]  busy_cnt
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [CNT_W-1:0]  r_busy_cnt;

    logic              w_wr_ok;
    logic              w_lk_ok;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [CNT_W-1:0]  w_busy_cnt_nxt;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;
    logic              w_busy1;
    logic              w_busy2;

    // A "live" address maps onto a real, writable register: in range and not
    // the hard-wired zero register. Everything else reads 0 / not busy and
    // swallows writes and locks, so out-of-range addresses never alias.
    function automatic logic f_live(input logic [ADDR_W-1:0] a);
        return (int'(a) < DEPTH) && !(ZERO_REG != 0 && a == '0);
    endfunction

    assign w_wr_ok = wen && f_live(waddr);
    assign w_lk_ok = lock_en && f_live(lock_addr);

    // Next busy vector: a retiring write clears, a new lock sets; lock wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_busy_nxt     = r_busy;
        w_busy_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_ok && int'(waddr) == i)
                w_busy_nxt[i] = 1'b0;
            if (w_lk_ok && int'(lock_addr) == i)
                w_busy_nxt[i] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++)
            w_busy_cnt_nxt = w_busy_cnt_nxt + CNT_W'(w_busy_nxt[i]);
    end

    // Combinational read ports, with same-cycle bypass of the write data.
    always_comb begin
        w_rdata1 = '0;
        w_rdata2 = '0;
        w_busy1  = 1'b0;
        w_busy2  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (f_live(raddr1) && int'(raddr1) == i) begin
                w_rdata1 = r_mem[i];
                w_busy1  = r_busy[i];
            end
            if (f_live(raddr2) && int'(raddr2) == i) begin
                w_rdata2 = r_mem[i];
                w_busy2  = r_busy[i];
            end
        end
        // Busy flags deliberately ignore the bypass: they show registered state only.
        if (BYPASS != 0 && w_wr_ok && raddr1 == waddr)
            w_rdata1 = wdata;
        if (BYPASS != 0 && w_wr_ok && raddr2 == waddr)
            w_rdata2 = wdata;
    end

    // Storage, busy vector and busy count; reset has priority over write/lock.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the array is reset because a defined RESET_VAL is part of the interface; this keeps it in flops, not RAM.
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= (ZERO_REG != 0 && i == 0) ? '0 : RESET_VAL;
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (w_wr_ok && int'(waddr) == i)
                    r_mem[i] <= wdata;
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_busy_cnt_nxt;
        end
    end

    assign rdata1   = w_rdata1;
    assign rdata2   = w_rdata2;
    assign busy1    = w_busy1;
    assign busy2    = w_busy2;
    assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: four instances cover bypass on/off,
// zero register, and a non-power-of-two depth.
module tb_regfile_param;

    logic        clk;
    logic        rst;
    logic [3:0]  raddr1, raddr2, waddr, lock_addr;
    logic        wen, lock_en;
    logic [15:0] wdata;

    // Per-instance outputs: a = bypass, b = no bypass, z = zero register.
    logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2, z_rd1, z_rd2;
    logic        a_b1, a_b2, b_b1, b_b2, z_b1, z_b2;
    logic [3:0]  a_cnt, b_cnt, z_cnt;

    // DEPTH=6 instance has its own narrower bus.
    logic [2:0]  s_raddr1, s_raddr2, s_waddr, s_lock_addr;
    logic        s_wen, s_lock_en;
    logic [15:0] s_wdata, s_rd1, s_rd2;
    logic        s_b1, s_b2;
    logic [2:0]  s_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_param #(.DATA_W(16), .DEPTH(8), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1),
                    .RESET_VAL(16'hA5A5)) u_a (
        .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(a_rd1), .rdata2(a_rd2), .wen(wen), .waddr(waddr), .wdata(wdata),
        .lock_en(lock_en), .lock_addr(lock_addr), .busy1(a_b1), .busy2(a_b2),
        .busy_cnt(a_cnt));

    regfile_param #(.DATA_W(16), .DEPTH(8), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0),
                    .RESET_VAL(16'hA5A5)) u_b (
        .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(b_rd1), .rdata2(b_rd2), .wen(wen), .waddr(waddr), .wdata(wdata),
        .lock_en(lock_en), .lock_addr(lock_addr), .busy1(b_b1), .busy2(b_b2),
        .busy_cnt(b_cnt));

    regfile_param #(.DATA_W(16), .DEPTH(8), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1),
                    .RESET_VAL(16'hA5A5)) u_z (
        .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(z_rd1), .rdata2(z_rd2), .wen(wen), .waddr(waddr), .wdata(wdata),
        .lock_en(lock_en), .lock_addr(lock_addr), .busy1(z_b1), .busy2(z_b2),
        .busy_cnt(z_cnt));

    regfile_param #(.DATA_W(16), .DEPTH(6), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1),
                    .RESET_VAL(16'h0000)) u_6 (
        .clk(clk), .rst(rst), .raddr1(s_raddr1), .raddr2(s_raddr2),
        .rdata1(s_rd1), .rdata2(s_rd2), .wen(s_wen), .waddr(s_waddr), .wdata(s_wdata),
        .lock_en(s_lock_en), .lock_addr(s_lock_addr), .busy1(s_b1), .busy2(s_b2),
        .busy_cnt(s_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and step clear of it before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wen     = 1'b0;
        lock_en = 1'b0;
        s_wen     = 1'b0;
        s_lock_en = 1'b0;
    endtask

    logic [15:0] data6 [6];

    initial begin
        data6 = '{16'h0101, 16'h1212, 16'h2323, 16'h3434, 16'h4545, 16'h5656};
        rst = 1'b1;
        raddr1 = '0; raddr2 = '0; waddr = '0; lock_addr = '0; wdata = '0;
        s_raddr1 = '0; s_raddr2 = '0; s_waddr = '0; s_lock_addr = '0; s_wdata = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state: every address on both ports reads RESET_VAL, not busy.
        for (int i = 0; i < 8; i++) begin
            raddr1 = 4'(i);
            raddr2 = 4'(7 - i);
            #1;
            check($sformatf("rst_rd1_%0d", i), 32'(a_rd1), 32'hA5A5);
            check($sformatf("rst_rd2_%0d", i), 32'(a_rd2), 32'hA5A5);
            check($sformatf("rst_busy1_%0d", i), 32'(a_b1), 32'h0);
            check($sformatf("rst_busy2_%0d", i), 32'(a_b2), 32'h0);
            tick();
        end
        check("rst_cnt", 32'(a_cnt), 32'h0);
        raddr1 = 4'd0;
        #1;
        check("rst_zero_reg", 32'(z_rd1), 32'h0);

        // Bypass: write 1234 to reg 3 while reading it.
        tick();
        wen = 1'b1; waddr = 4'd3; wdata = 16'h1234; raddr1 = 4'd3;
        #1;
        check("byp1_same_cycle", 32'(a_rd1), 32'h1234);
        check("byp0_same_cycle", 32'(b_rd1), 32'hA5A5);
        tick();
        idle();
        #1;
        check("byp0_next_cycle", 32'(b_rd1), 32'h1234);
        check("byp1_next_cycle", 32'(a_rd1), 32'h1234);

        // Zero register and out-of-range: seed reg 1, then hit addr 0 and 9.
        wen = 1'b1; waddr = 4'd1; wdata = 16'h1111;
        tick();
        waddr = 4'd0; wdata = 16'hFFFF; raddr1 = 4'd0;
        #1;
        check("zero_no_bypass", 32'(z_rd1), 32'h0);
        check("nozero_bypass0", 32'(a_rd1), 32'hFFFF);
        tick();
        waddr = 4'd9; raddr1 = 4'd9;
        #1;
        check("oor_rd_zreg", 32'(z_rd1), 32'h0);
        check("oor_rd", 32'(a_rd1), 32'h0);
        tick();
        idle();
        raddr1 = 4'd0; raddr2 = 4'd1;
        #1;
        check("zero_after_wr", 32'(z_rd1), 32'h0);
        check("zreg_r1_kept", 32'(z_rd2), 32'h1111);
        check("reg0_written", 32'(a_rd1), 32'hFFFF);
        check("no_alias_r1", 32'(a_rd2), 32'h1111);
        check("no_alias_r1_b", 32'(b_rd2), 32'h1111);
        raddr1 = 4'd9;
        #1;
        check("oor_after_wr", 32'(a_rd1), 32'h0);
        lock_en = 1'b1; lock_addr = 4'd0;
        tick();
        lock_addr = 4'd9;
        tick();
        idle();
        raddr1 = 4'd0; raddr2 = 4'd9;
        #1;
        check("zero_lock_busy", 32'(z_b1), 32'h0);
        check("zero_lock_cnt", 32'(z_cnt), 32'h0);
        check("reg0_lock_busy", 32'(a_b1), 32'h1);
        check("oor_lock_busy", 32'(a_b2), 32'h0);
        check("reg0_lock_cnt", 32'(a_cnt), 32'h1);

        // Scoreboard on reg 5.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lock_en = 1'b1; lock_addr = 4'd5;
        tick();
        idle();
        raddr1 = 4'd5; raddr2 = 4'd5;
        #1;
        check("lock_busy1", 32'(a_b1), 32'h1);
        check("lock_busy2", 32'(a_b2), 32'h1);
        check("lock_cnt", 32'(a_cnt), 32'h1);
        wen = 1'b1; waddr = 4'd5; wdata = 16'h5555;
        #1;
        check("busy_not_comb_cleared", 32'(a_b1), 32'h1);
        tick();
        idle();
        #1;
        check("wr_clears_busy", 32'(a_b1), 32'h0);
        check("wr_clears_cnt", 32'(a_cnt), 32'h0);
        check("wr_data", 32'(a_rd1), 32'h5555);
        wen = 1'b1; waddr = 4'd5; wdata = 16'h7777;
        lock_en = 1'b1; lock_addr = 4'd5;
        tick();
        idle();
        #1;
        check("lockwr_busy", 32'(a_b1), 32'h1);
        check("lockwr_data", 32'(a_rd1), 32'h7777);
        check("lockwr_cnt", 32'(a_cnt), 32'h1);

        // Reset mid-operation (reg 5 still busy).
        lock_en = 1'b1; lock_addr = 4'd2;
        tick();
        lock_addr = 4'd4;
        tick();
        lock_addr = 4'd6; wen = 1'b1; waddr = 4'd2; wdata = 16'h2222;
        tick();
        idle();
        raddr1 = 4'd2; raddr2 = 4'd4;
        #1;
        check("mid_cnt", 32'(a_cnt), 32'h3);
        check("mid_busy2_clr", 32'(a_b1), 32'h0);
        check("mid_busy4_set", 32'(a_b2), 32'h1);
        check("mid_data2", 32'(a_rd1), 32'h2222);
        rst = 1'b1;
        wen = 1'b1; waddr = 4'd7; wdata = 16'hBEEF;
        lock_en = 1'b1; lock_addr = 4'd7;
        tick();
        rst = 1'b0;
        idle();
        #1;
        check("mid_rst_cnt", 32'(a_cnt), 32'h0);
        for (int i = 0; i < 8; i++) begin
            raddr1 = 4'(i);
            #1;
            check($sformatf("mid_rst_rd_%0d", i), 32'(a_rd1), 32'hA5A5);
            check($sformatf("mid_rst_busy_%0d", i), 32'(a_b1), 32'h0);
            tick();
        end

        // Non-power-of-two depth.
        for (int i = 0; i < 6; i++) begin
            s_wen = 1'b1; s_waddr = 3'(i); s_wdata = data6[i];
            tick();
        end
        s_waddr = 3'd6; s_wdata = 16'hFFFF;
        tick();
        s_waddr = 3'd7;
        tick();
        idle();
        for (int i = 0; i < 6; i++) begin
            s_raddr1 = 3'(i);
            s_raddr2 = 3'(5 - i);
            #1;
            check($sformatf("d6_rd1_%0d", i), 32'(s_rd1), 32'(data6[i]));
            check($sformatf("d6_rd2_%0d", i), 32'(s_rd2), 32'(data6[5 - i]));
            tick();
        end
        s_raddr1 = 3'd6; s_raddr2 = 3'd7;
        #1;
        check("d6_rd_addr6", 32'(s_rd1), 32'h0);
        check("d6_rd_addr7", 32'(s_rd2), 32'h0);
        s_lock_en = 1'b1; s_lock_addr = 3'd7;
        tick();
        s_lock_addr = 3'd5;
        tick();
        idle();
        s_raddr1 = 3'd5;
        #1;
        check("d6_oor_lock_cnt", 32'(s_cnt), 32'h1);
        check("d6_busy5", 32'(s_b1), 32'h1);
        check("d6_busy7", 32'(s_b2), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
